// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a barrel shifter.
module alu_exec_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_RL = 2'd1;
    localparam logic [1:0] SH_RA = 2'd2;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            ill_q, ill_d;

    logic [SHW-1:0]  shamt;
    logic [SHW-1:0]  amt;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    function automatic logic [XLEN-1:0] sh(
        input logic [XLEN-1:0] v,
        input logic [1:0]      k,
        input logic [SHW-1:0]  n
    );
        case (k)
            SH_LL:   sh = v << n;
            SH_RL:   sh = v >> n;
            default: sh = $signed(v) >>> n;
        endcase
    endfunction

    assign shamt = op_b[SHW-1:0];

`ifdef ALU_FAST_SHIFT_EN
    assign amt = shamt;
`else
    // Iterative build: the single-cycle path only ever sees shamt == 0
    assign amt = '0;

    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [1:0]      kind_q, kind_d;
    logic [1:0]      kind;
    logic            is_shift;
    logic [XLEN-1:0] step;

    assign is_shift = (alu_ctrl == 4'b0011) ||
                      (alu_ctrl == 4'b1000) ||
                      (alu_ctrl == 4'b1010);
    assign kind = (alu_ctrl == 4'b1000) ? SH_RL :
                  (alu_ctrl == 4'b1010) ? SH_RA : SH_LL;
    assign step = sh(res_q, kind_q, SHW'(1));
`endif

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = op_a ^ op_b;
            4'b0100: alu_res = {{(XLEN-1){1'b0}},
                                ($signed(op_a) < $signed(op_b))};
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'b0011: alu_res = sh(op_a, SH_LL, amt);
            4'b1000: alu_res = sh(op_a, SH_RL, amt);
            4'b1010: alu_res = sh(op_a, SH_RA, amt);
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
`ifndef ALU_FAST_SHIFT_EN
        cnt_d   = cnt_q;
        kind_d  = kind_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
`ifndef ALU_FAST_SHIFT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
                        if (is_shift && shamt != '0) begin
                            state_d = S_SHIFT;
                            res_d   = op_a;
                            cnt_d   = shamt;
                            kind_d  = kind;
                            zero_d  = 1'b0;
                            ill_d   = 1'b0;
                        end else
`endif
                        begin
                            state_d = S_DONE;
                            res_d   = alu_res;
                            zero_d  = (alu_res == '0);
                            ill_d   = alu_ill;
                        end
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                S_SHIFT: begin
                    res_d = step;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d = S_DONE;
                        zero_d  = (step == '0);
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

`ifndef ALU_FAST_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            kind_q <= SH_LL;
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
        end
    end
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus backpressure,
// flush and asynchronous-reset sequences.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    vec_t vt[16];

    task automatic run_op(input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic z, output logic il, output int lat);
        chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r  = result;
        z  = zero;
        il = illegal;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        z;
        logic        il;
        int          lat;
        int          elat;

        // ctrl, a, b, result, zero, illegal, latency (iterative build)
        vt[0]  = '{4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1};
        vt[1]  = '{4'b0110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1};
        vt[2]  = '{4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5};
        vt[3]  = '{4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1};
        vt[4]  = '{4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1};
        vt[5]  = '{4'b1111, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 1'b1, 1};
        vt[6]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1};
        vt[7]  = '{4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 1};
        vt[8]  = '{4'b0011, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32};
        vt[9]  = '{4'b1000, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 32};
        vt[10] = '{4'b0011, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1'b0, 1};
        vt[11] = '{4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vt[12] = '{4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1};
        vt[13] = '{4'b1000, 32'h0000_00F0, 32'h0000_0104, 32'h0000_000F, 1'b0, 1'b0, 5};
        vt[14] = '{4'b1001, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, 1};
        vt[15] = '{4'b1010, 32'h7000_0000, 32'd1, 32'h3800_0000, 1'b0, 1'b0, 2};

        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
`ifdef ALU_FAST_SHIFT_EN
            elat = 1;
`else
            elat = vt[i].lat;
`endif
            run_op(vt[i].ctrl, vt[i].a, vt[i].b, r, z, il, lat);
            chk($sformatf("v%0d_res", i), r, vt[i].res);
            chk($sformatf("v%0d_zero", i), {31'd0, z}, {31'd0, vt[i].z});
            chk($sformatf("v%0d_ill", i), {31'd0, il}, {31'd0, vt[i].il});
            chk($sformatf("v%0d_lat", i), lat, elat);
        end

        // backpressure on an xor
        out_ready = 1'b0;
        alu_ctrl  = 4'b0111;
        op_a      = 32'h0000_F0F0;
        op_b      = 32'h0000_0FF0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, 32'h0000_FF00);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_rel_valid", {31'd0, out_valid}, 32'd0);

        // flush with in_valid in the same cycle
        out_ready = 1'b0;
        alu_ctrl  = 4'b0011;
        op_a      = 32'd1;
        op_b      = 32'd31;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
        chk("fl_fast_valid", {31'd0, out_valid}, 32'd1);
`else
        for (int i = 0; i < 9; i++) begin
            chk("fl_shift_valid", {31'd0, out_valid}, 32'd0);
            chk("fl_shift_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
`endif
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("fl_after_valid", {31'd0, out_valid}, 32'd0);
            chk("fl_after_in_ready", {31'd0, in_ready}, 32'd1);
        end
        out_ready = 1'b1;

        // asynchronous reset in the middle of an sll by 20
        alu_ctrl = 4'b0011;
        op_a     = 32'd1;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'b0010, 32'd3, 32'd4, r, z, il, lat);
        chk("post_rst_res", r, 32'd7);
        chk("post_rst_zero", {31'd0, z}, 32'd0);
        chk("post_rst_lat", lat, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
